// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the 2-input gate self-test sequencer.
// Truth tables are indexed by {a,b}: bit 0 is a=0,b=0 and bit 3 is a=1,b=1.
package gate_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } seq_state_e;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

    localparam int CNT_W = 4;

endpackage

// File: rtl/gate_exercise_seq_if.sv
// Control, gate-drive and result signals between the sequencer and its surroundings.
// The master is the sequencer; the slave is the gate datapath plus whoever requests runs.
interface gate_exercise_seq_if;

    logic       start;
    logic       gate_a;
    logic       gate_b;
    logic       gate_y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] err_mask;

    modport master (
        input  start, gate_y,
        output gate_a, gate_b, busy, done, pass, err_count, err_mask
    );

    modport slave (
        output start, gate_y,
        input  gate_a, gate_b, busy, done, pass, err_count, err_mask
    );

endinterface

// File: rtl/gate_exercise_seq_settle_timer.sv
// Settle interval counter: cleared by load, advanced by en, expire flags the last settle cycle.
module settle_timer
    import gate_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;

    // Settle count register; load wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = (cnt_r == LAST_CNT);

endmodule

// File: rtl/gate_exercise_seq.sv
// Self-test sequencer: walks a 2-input gate through 00,01,10,11, samples its output
// after a settle interval and records mismatches against the TRUTH table.
module gate_exercise_seq
    import gate_seq_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] TRUTH         = TT_OR
) (
    input  logic                clk,
    input  logic                rst,
    gate_exercise_seq_if.master bus
);

    seq_state_e state_r;
    logic [1:0] idx_r;
    logic       gate_a_r;
    logic       gate_b_r;
    logic       busy_r;
    logic       done_r;
    logic       pass_r;
    logic [2:0] err_count_r;
    logic [3:0] err_mask_r;

    logic load_s;
    logic en_s;
    logic expire_s;
    logic mismatch_s;

    // Timer control: restart at run acceptance and before every new combination.
    always_comb begin
        load_s     = 1'b0;
        en_s       = 1'b0;
        mismatch_s = (bus.gate_y != TRUTH[idx_r]);
        if ((state_r == IDLE) && bus.start) begin
            load_s = 1'b1;
        end else if (state_r == SAMPLE) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
        if (state_r == SETTLE) begin
            en_s = 1'b1;
        end else begin
            en_s = 1'b0;
        end
    end

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (load_s),
        .en    (en_s),
        .expire(expire_s)
    );

    // Sequencer FSM with all outputs registered; done is a one-cycle pulse after FINISH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= 2'd0;
            gate_a_r    <= 1'b0;
            gate_b_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            err_count_r <= 3'd0;
            err_mask_r  <= 4'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        idx_r       <= 2'd0;
                        gate_a_r    <= 1'b0;
                        gate_b_r    <= 1'b0;
                        err_count_r <= 3'd0;
                        err_mask_r  <= 4'd0;
                        pass_r      <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (expire_s) begin
                        state_r <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (mismatch_s) begin
                        err_count_r        <= err_count_r + 3'd1;
                        err_mask_r[idx_r]  <= 1'b1;
                    end
                    if (idx_r == 2'd3) begin
                        state_r <= FINISH;
                    end else begin
                        idx_r                <= idx_r + 2'd1;
                        {gate_a_r, gate_b_r} <= idx_r + 2'd1;
                        state_r              <= SETTLE;
                    end
                end
                FINISH: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    pass_r  <= (err_count_r == 3'd0);
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.gate_a    = gate_a_r;
    assign bus.gate_b    = gate_b_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.err_count = err_count_r;
    assign bus.err_mask  = err_mask_r;

endmodule
